// File: rtl/cache_pkg.sv
// Shared types and address/data helpers for the two-way data cache.
package cache_pkg;

  // Widest address the helper functions accept; callers zero-extend into it.
  localparam int MAX_ADDR_W = 64;

  // Default geometry; the cache top recomputes these from its own parameters.
  localparam int DEF_SETS   = 8;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_IDX_W  = $clog2(DEF_SETS);
  localparam int DEF_TAG_W  = DEF_ADDR_W - 2 - DEF_IDX_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cache_state_t;

  // Set index: word-address bits just above the byte offset.
  function automatic logic [MAX_ADDR_W-1:0] idx_of(input logic [MAX_ADDR_W-1:0] addr,
                                                   input int idx_w);
    return (addr >> 2) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  // Tag: everything above the index.
  function automatic logic [MAX_ADDR_W-1:0] tag_of(input logic [MAX_ADDR_W-1:0] addr,
                                                   input int idx_w);
    return addr >> (idx_w + 2);
  endfunction

  // Replace the bytes of old_word selected by strb with those of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid/tag/data per set, combinational lookup,
// a full-line fill port and a byte-masked store-update port.
module cache_way
  import cache_pkg::*;
#(
  parameter int SETS   = 8,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 27,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic [TAG_W-1:0]  tag,
  output logic              hit,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  input  logic              fill_en,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              upd_en,
  input  logic [DATA_W-1:0] upd_data,
  input  logic [3:0]        upd_strb
);

  logic [SETS-1:0]   valid_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [DATA_W-1:0] data_q [SETS];

  assign valid = valid_q[idx];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag);
  assign rdata = data_q[idx];

  // Array storage: cleared on reset, written by a refill or by a store hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        tag_q[s]  <= '0;
        data_q[s] <= '0;
      end
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      tag_q[idx]   <= tag;
      data_q[idx]  <= fill_data;
    end else if (upd_en) begin
      data_q[idx] <= DATA_W'(merge_bytes(32'(data_q[idx]), 32'(upd_data), upd_strb));
    end
  end

endmodule

// File: rtl/dcache_2way.sv
// Two-way set-associative write-through / no-write-allocate data cache
// with per-set LRU, a refill/write FSM and a pipeline stall output.
module dcache_2way
  import cache_pkg::*;
#(
  parameter int SETS   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic [3:0]        cpu_wstrb_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_stall_o,
  output logic              hit_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ready_i
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;

  cache_state_t      state, next_state;
  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic [1:0]        way_hit, way_valid, fill_en, upd_en;
  logic [DATA_W-1:0] way_rdata [2];
  logic              hit, hit_way, victim;
  logic [SETS-1:0]   lru;
  logic              lru_we, lru_val;
  logic              ack;

  assign idx = IDX_W'(idx_of(MAX_ADDR_W'(cpu_addr_i), IDX_W));
  assign tag = TAG_W'(tag_of(MAX_ADDR_W'(cpu_addr_i), IDX_W));

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .DATA_W(DATA_W)
    ) u_way (
      .clk      (clk),
      .rst_n    (rst_n),
      .idx      (idx),
      .tag      (tag),
      .hit      (way_hit[w]),
      .valid    (way_valid[w]),
      .rdata    (way_rdata[w]),
      .fill_en  (fill_en[w]),
      .fill_data(mem_rdata_i),
      .upd_en   (upd_en[w]),
      .upd_data (cpu_wdata_i),
      .upd_strb (cpu_wstrb_i)
    );
  end

  // Both ways never match together, so way1's hit alone names the hit way.
  assign hit     = cpu_req_i & (|way_hit);
  assign hit_way = way_hit[1];
  assign hit_o   = hit;
  assign victim  = !way_valid[0] ? 1'b0 : (!way_valid[1] ? 1'b1 : lru[idx]);
  assign cpu_rdata_o = (cpu_req_i && !cpu_we_i && hit) ? way_rdata[hit_way] : '0;

  // State register; reset drops any memory request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // ack marks the IDLE cycle right after a memory transfer completes:
  // a store retires there, a load spends it as its settle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack <= 1'b0;
    else        ack <= (state != IDLE) && mem_ready_i;
  end

  // LRU bit per set names the way to evict next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      lru      <= '0;
    else if (lru_we) lru[idx] <= lru_val;
  end

  // Next-state, stall, memory-interface and array-write control.
  always_comb begin
    next_state  = state;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    fill_en     = '0;
    upd_en      = '0;
    lru_we      = 1'b0;
    lru_val     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req_i) begin
          if (ack) begin
            cpu_stall_o = !cpu_we_i;
          end else if (cpu_we_i) begin
            cpu_stall_o = 1'b1;
            next_state  = WRITE;
          end else if (hit) begin
            lru_we  = 1'b1;
            lru_val = !hit_way;
          end else begin
            cpu_stall_o = 1'b1;
            next_state  = REFILL;
          end
        end
      end
      REFILL: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {cpu_addr_i[ADDR_W-1:2], 2'b00};
        if (mem_ready_i) begin
          fill_en[victim] = 1'b1;
          lru_we          = 1'b1;
          lru_val         = !victim;
          next_state      = IDLE;
        end
      end
      WRITE: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {cpu_addr_i[ADDR_W-1:2], 2'b00};
        mem_wdata_o = cpu_wdata_i;
        mem_wstrb_o = cpu_wstrb_i;
        if (mem_ready_i) begin
          if (hit) begin
            upd_en[hit_way] = 1'b1;
            lru_we          = 1'b1;
            lru_val         = !hit_way;
          end
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: doc/dcache_2way.md
# dcache_2way

Parametrised two-way set-associative data cache sitting between the RV32I memory stage and data memory, replacing the single-way, single-word store used so far. It adds per-set LRU replacement, byte-enabled stores, a write-through/no-write-allocate policy, a miss-refill state machine with a ready/request memory handshake, and a stall output that holds the pipeline while memory is busy.

## Interface
- `SETS`, 8, number of sets; power of two, ≥2
- `ADDR_W`, 32, byte address width
- `DATA_W`, 32, word width; one word per line
- `clk` in 1 — clock, rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `cpu_req_i` in 1 — access valid this cycle
- `cpu_we_i` in 1 — 1 = store, 0 = load
- `cpu_addr_i` in ADDR_W — byte address; bits [1:0] are ignored
- `cpu_wdata_i` in DATA_W — store data
- `cpu_wstrb_i` in 4 — store byte enables
- `cpu_rdata_o` out DATA_W — load data; valid when `cpu_req_i & ~cpu_we_i & ~cpu_stall_o`
- `cpu_stall_o` out 1 — pipeline must hold the request unchanged
- `hit_o` out 1 — lookup hit, combinational
- `mem_req_o` out 1 — memory request
- `mem_we_o` out 1 — memory write
- `mem_addr_o` out ADDR_W — word-aligned address ([1:0] = 0)
- `mem_wdata_o` out DATA_W, `mem_wstrb_o` out 4 — write data and byte enables
- `mem_rdata_i` in DATA_W — refill data
- `mem_ready_i` in 1 — memory completes the request on this edge

## Operation
- Address split:
  - index = addr[IDX_W+1:2], where IDX_W = log2(SETS)
  - tag = addr[ADDR_W-1:IDX_W+2]
  - TAG_W = ADDR_W-2-IDX_W
- Per set and per way: valid bit, tag, data word. Per set: one LRU bit (the way to evict next).
- Hit: `cpu_req_i` and some way has valid=1 with a matching tag. Both ways can never match at once.
- FSM states: IDLE, REFILL, WRITE.
- **IDLE**
  - Load hit: `cpu_rdata_o` = data of the hit way, stall=0. At the edge, LRU is set to the other way.
  - Load miss: stall=1 and next state is REFILL.
  - Store, hit or miss: stall=1 and next state is WRITE.
  - No request: stall=0.
- **REFILL**
  - Drives `mem_req_o`=1, `mem_we_o`=0, `mem_addr_o`={tag,index,2'b00}.
  - On the edge with `mem_ready_i`=1:
    - Victim way: way0 if invalid, else way1 if invalid, else the LRU way.
    - Victim gets valid=1, the tag and `mem_rdata_i`.
    - LRU is set to the other way; next state is IDLE.
  - The retried load hits in IDLE on the following cycle.
- **WRITE**
  - Drives `mem_req_o`=1, `mem_we_o`=1 with data and strobes.
  - On the edge with `mem_ready_i`=1:
    - If the address hits, the hit way's bytes selected by `cpu_wstrb_i` are merged and LRU is updated.
    - On a miss, no allocation is made and the arrays are unchanged.
    - Next state is IDLE, with stall=0 that cycle (the store retires).
- Stall in REFILL and WRITE: stall=1 every cycle, including the `mem_ready_i` cycle.

## Timing
- Reset values:
  - All valid and LRU bits 0, state IDLE.
  - `mem_req_o`, `mem_we_o`, `cpu_stall_o`, `hit_o` = 0.
  - `mem_addr_o`, `mem_wdata_o`, `mem_wstrb_o`, `cpu_rdata_o` = 0 while no request is active.
- Load hit: 0-cycle latency, combinational data.
- Load miss: stall for 1 + N + 1 cycles, where N = cycles from `mem_req_o` up to and including `mem_ready_i`. Minimum total is 3.
- Store: stall for 1 + N cycles, then retires in IDLE the cycle after completion. Minimum is 2 stall cycles.
- `mem_ready_i` is ignored outside REFILL and WRITE.
- `mem_ready_i` may assert in the first cycle of `mem_req_o`.
- Memory-side outputs are stable from request until ready.
- Reset mid-operation: FSM returns to IDLE and arrays are invalidated. `mem_req_o` drops asynchronously and no partial line is written.
- A store with `cpu_wstrb_i`=0 still performs the memory handshake and leaves the cache data unchanged.
- Load immediately after a store to the same hitting address returns the merged word with 0 latency.

## Structure
- Shared package `cache_pkg`:
  - `cache_state_t` enum: IDLE, REFILL, WRITE
  - Functions `idx_of()`, `tag_of()`, `merge_bytes(old, new, strb)`
  - Localparam formulas for IDX_W and TAG_W
- Sub-module `cache_way`, instantiated twice:
  - Contents: valid/tag/data arrays for SETS entries, with async clear on `rst_n`.
  - Read: combinational, giving `hit` and `rdata`.
  - Writes: a fill port (full word with tag) and a byte-masked update port.
- Top level holds the FSM, the LRU bits, victim selection and the memory-interface muxing.

## Test plan
- Cold load, SETS=8, addr 0x0000_0040, memory returns 0xDEADBEEF after 2 wait cycles:
  - `mem_req_o` rises the cycle after the request; stall lasts 5 cycles.
  - The next cycle has a hit with `cpu_rdata_o`=0xDEADBEEF.
- Conflict/LRU: load 0x040, 0x140, load 0x040 again, then load 0x240:
  - The 0x240 refill evicts the 0x140 way.
  - A reload of 0x040 hits; a reload of 0x140 misses.
- Store with strb 4'b0010 and wdata 0x0000AB00 to cached 0x040, holding 0x11223344:
  - Memory sees the write with strb 0010.
  - A subsequent load hits with 0x1122AB44.
- Store miss to 0x300: memory write occurs, then a load of 0x300 misses (no allocate).
- Zero-wait memory (`mem_ready_i` tied to 1): load miss stalls exactly 3 cycles; store stalls exactly 2.
- Reset asserted during REFILL:
  - `mem_req_o` goes to 0 immediately.
  - After release, the previously cached 0x040 misses.
